// File: rtl/t1c_riscv_cpu.sv
// t1c_riscv_cpu: single-cycle RV32I core with an instruction ROM and a byte-lane data RAM.
// While reset is held, the data-memory port belongs to the Ext_* inputs so memory can be preloaded.
module t1c_riscv_cpu #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "riscvtest.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ext_MemWrite,
  input  logic [31:0] Ext_WriteData,
  input  logic [31:0] Ext_DataAdr,
  output logic        MemWrite,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic [31:0] ReadData,
  output logic [31:0] PC,
  output logic [31:0] Result
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  logic [31:0] instr, rs1v, rs2v, pcPlus4, pcNext;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [31:0] aluB, aluResult, loadData, laneData;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, aluF3;
  logic [3:0]  byteEn;
  logic        regWrite, storeEn, aluSub, takeBranch;
  logic signed [31:0] rs1s, rs2s;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  function automatic logic [31:0] aluOp(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic sub);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'b000:  aluOp = sub ? a - b : a + b;
      3'b001:  aluOp = a << b[4:0];
      3'b010:  aluOp = {31'd0, $signed(a) < $signed(b)};
      3'b011:  aluOp = {31'd0, a < b};
      3'b100:  aluOp = a ^ b;
      3'b101:  aluOp = sub ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'b110:  aluOp = a | b;
      default: aluOp = a & b;
    endcase
  endfunction

  assign instr  = imem[PC[IW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1v = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign rs1s = rs1v;
  assign rs2s = rs2v;

  assign immI = {{20{instr[31]}}, instr[31:20]};
  assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {instr[31:12], 12'd0};
  assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Address-forming ops (load/store/jalr) and branches force the adder path of the ALU.
  always_comb begin
    regWrite = 1'b0;
    storeEn  = 1'b0;
    aluB     = immI;
    aluF3    = funct3;
    aluSub   = 1'b0;
    case (opcode)
      OP_REG: begin
        regWrite = 1'b1;
        aluB     = rs2v;
        aluSub   = instr[30];
      end
      OP_IMM: begin
        regWrite = 1'b1;
        aluSub   = instr[30] && (funct3 == 3'b101);
      end
      OP_LOAD: begin
        regWrite = 1'b1;
        aluF3    = 3'b000;
      end
      OP_STORE: begin
        storeEn = funct3 inside {3'b000, 3'b001, 3'b010};
        aluB    = immS;
        aluF3   = 3'b000;
      end
      OP_BRANCH: begin
        aluB   = rs2v;
        aluF3  = 3'b000;
        aluSub = 1'b1;
      end
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        regWrite = 1'b1;
        aluF3    = 3'b000;
      end
      default: ;
    endcase
  end

  assign aluResult = aluOp(rs1v, aluB, aluF3, aluSub);

  always_comb begin
    case (funct3)
      3'b000:  takeBranch = (rs1v == rs2v);
      3'b001:  takeBranch = (rs1v != rs2v);
      3'b100:  takeBranch = (rs1s < rs2s);
      3'b101:  takeBranch = (rs1s >= rs2s);
      3'b110:  takeBranch = (rs1v < rs2v);
      3'b111:  takeBranch = (rs1v >= rs2v);
      default: takeBranch = 1'b0;
    endcase
  end

  assign pcPlus4 = PC + 32'd4;

  always_comb begin
    pcNext = pcPlus4;
    if (opcode == OP_JAL)
      pcNext = PC + immJ;
    else if (opcode == OP_BRANCH && takeBranch)
      pcNext = PC + immB;
    else if (opcode == OP_JALR)
      pcNext = {aluResult[31:1], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) PC <= 32'd0;
    else       PC <= pcNext;
  end

  // During reset the external port owns the data memory and the core is silenced.
  assign MemWrite  = reset ? Ext_MemWrite  : storeEn;
  assign WriteData = reset ? Ext_WriteData : rs2v;
  assign DataAdr   = reset ? Ext_DataAdr   : aluResult;
  assign ReadData  = dmem[DataAdr[DW+1:2]];

  assign loadByte = ReadData[{DataAdr[1:0], 3'b000} +: 8];
  assign loadHalf = DataAdr[1] ? ReadData[31:16] : ReadData[15:0];

  always_comb begin
    case (funct3)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'd0, loadByte};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = ReadData;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD:          Result = loadData;
      OP_JAL, OP_JALR:  Result = pcPlus4;
      OP_LUI:           Result = immU;
      OP_AUIPC:         Result = PC + immU;
      default:          Result = aluResult;
    endcase
  end

  // Sub-word stores replicate the datum across lanes and enable only the addressed ones.
  always_comb begin
    byteEn   = 4'b1111;
    laneData = Ext_WriteData;
    if (!reset) begin
      case (funct3)
        3'b000: begin
          byteEn   = 4'b0001 << DataAdr[1:0];
          laneData = {4{rs2v[7:0]}};
        end
        3'b001: begin
          byteEn   = DataAdr[1] ? 4'b1100 : 4'b0011;
          laneData = {2{rs2v[15:0]}};
        end
        default: laneData = rs2v;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) dmem[DataAdr[DW+1:2]][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (regWrite && !reset && rd != 5'd0) regs[rd] <= Result;
  end

endmodule

// File: tb/tb_t1c_riscv_cpu.sv
// Directed bench for t1c_riscv_cpu: programs are written into the instruction ROM, expected
// outputs are queued alongside each step and compared against the DUT after it settles.
module tb_t1c_riscv_cpu;
  logic        clk = 1'b0;
  logic        reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData, Ext_DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData, DataAdr, ReadData, PC, Result;

  int checks = 0;
  int failures = 0;

  localparam int S_PC = 0, S_RES = 1, S_ADR = 2, S_WD = 3, S_RD = 4, S_MW = 5;
  localparam logic [31:0] PARK = 32'h0000_0063;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [6:0] O_LOAD = 7'h03, O_IMM = 7'h13, O_AUIPC = 7'h17, O_LUI = 7'h37, O_JALR = 7'h67;

  typedef struct { string tag; int sig; logic [31:0] val; } exp_t;
  typedef struct { logic [31:0] adr; logic [31:0] data; } store_t;
  exp_t        expQ[$];
  store_t      storeQ[$];
  logic [31:0] prog[$];

  t1c_riscv_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset), .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr), .MemWrite(MemWrite), .WriteData(WriteData), .DataAdr(DataAdr),
    .ReadData(ReadData), .PC(PC), .Result(Result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encI(input int imm, input int rs1, input int f3, input int rd,
                                       input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encR(input int f7, input int rs2, input int rs1, input int f3,
                                       input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] encU(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] encJ(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic loadProg();
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : PARK;
    prog.delete();
  endtask

  task automatic expect_(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_PC:    return PC;
      S_RES:   return Result;
      S_ADR:   return DataAdr;
      S_WD:    return WriteData;
      S_RD:    return ReadData;
      default: return {31'd0, MemWrite};
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic checkAll();
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      cmp(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "timeout");
  end

  initial begin
    store_t s;
    reset = 1'b1;
    Ext_MemWrite = 1'b0;
    Ext_WriteData = 32'd0;
    Ext_DataAdr = 32'd0;

    // Harris & Harris riscvtest image
    prog = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
             32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
             32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
             32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
             32'h00210063};
    loadProg();
    @(negedge clk);
    @(negedge clk);
    #1;
    expect_("reset_pc", S_PC, 32'd0);
    expect_("reset_memwrite", S_MW, 32'd0);
    checkAll();

    reset = 1'b0;
    #1;
    s.adr = 32'd96;  s.data = 32'd7;  storeQ.push_back(s);
    s.adr = 32'd100; s.data = 32'd25; storeQ.push_back(s);
    for (int c = 0; c < 40; c++) begin
      if (MemWrite) begin
        checks++;
        assert (storeQ.size() > 0)
        else begin
          failures++;
          $error("FAIL unexpected_store observed adr=0x%08h data=0x%08h expected no store", DataAdr, WriteData);
        end
        if (storeQ.size() > 0) begin
          s = storeQ.pop_front();
          cmp("riscvtest_store_adr", DataAdr, s.adr);
          cmp("riscvtest_store_data", WriteData, s.data);
        end
      end
      step();
    end
    cmp("riscvtest_missing_stores", 32'(storeQ.size()), 32'd0);
    cmp("riscvtest_done_pc", PC, 32'h50);

    // External preload during reset, then lw/sw of the preloaded word
    reset = 1'b1;
    prog = '{encI(32'h20, 0, 2, 5, O_LOAD), encS(32'h24, 5, 0, 2)};
    loadProg();
    Ext_MemWrite = 1'b1;
    Ext_DataAdr = 32'h20;
    Ext_WriteData = 32'hDEADBEEF;
    #1;
    expect_("ext_pc", S_PC, 32'd0);
    expect_("ext_memwrite", S_MW, 32'd1);
    expect_("ext_dataadr", S_ADR, 32'h20);
    expect_("ext_writedata", S_WD, 32'hDEADBEEF);
    checkAll();
    expect_("ext_readback", S_RD, 32'hDEADBEEF);
    step();
    checkAll();
    Ext_MemWrite = 1'b0;
    reset = 1'b0;
    #1;
    expect_("lw_ext_result", S_RES, 32'hDEADBEEF);
    expect_("lw_ext_memwrite", S_MW, 32'd0);
    checkAll();
    expect_("sw_ext_memwrite", S_MW, 32'd1);
    expect_("sw_ext_adr", S_ADR, 32'h24);
    expect_("sw_ext_data", S_WD, 32'hDEADBEEF);
    step();
    checkAll();
    step();
    reset = 1'b1;
    Ext_DataAdr = 32'h24;
    #1;
    expect_("sw_ext_readback", S_RD, 32'hDEADBEEF);
    checkAll();

    // Loads and stores on word 0
    prog = '{encU(32'h12345, 1, O_LUI), encI(32'h680, 1, 0, 1, O_IMM), encS(0, 1, 0, 2),
             encI(32'hAB, 0, 0, 2, O_IMM), encS(1, 2, 0, 0), encI(0, 0, 2, 3, O_LOAD),
             encI(0, 0, 0, 4, O_LOAD), encI(0, 0, 4, 4, O_LOAD), encI(0, 0, 1, 4, O_LOAD),
             encI(2, 0, 5, 4, O_LOAD), encI(3, 0, 0, 4, O_LOAD), encI(5, 0, 0, 0, O_IMM),
             encR(0, 0, 0, 0, 1), encS(2, 2, 0, 1), encI(0, 0, 2, 3, O_LOAD)};
    loadProg();
    reset = 1'b0;
    #1;
    expect_("lui_result", S_RES, 32'h12345000); checkAll(); step();
    expect_("addi_result", S_RES, 32'h12345680); checkAll(); step();
    expect_("sw_memwrite", S_MW, 32'd1);
    expect_("sw_adr", S_ADR, 32'd0);
    expect_("sw_data", S_WD, 32'h12345680); checkAll(); step();
    step();
    expect_("sb_memwrite", S_MW, 32'd1);
    expect_("sb_adr", S_ADR, 32'd1);
    expect_("sb_data", S_WD, 32'h000000AB); checkAll(); step();
    expect_("sb_lanes_lw", S_RES, 32'h1234AB80); checkAll(); step();
    expect_("lb_sign", S_RES, 32'hFFFFFF80); checkAll(); step();
    expect_("lbu_zero", S_RES, 32'h00000080); checkAll(); step();
    expect_("lh_sign", S_RES, 32'hFFFFAB80); checkAll(); step();
    expect_("lhu_upper", S_RES, 32'h00001234); checkAll(); step();
    expect_("lb_lane3", S_RES, 32'h00000012); checkAll(); step();
    expect_("addi_x0_memwrite", S_MW, 32'd0); checkAll(); step();
    expect_("add_x0_x0", S_RES, 32'd0); checkAll(); step();
    expect_("sh_memwrite", S_MW, 32'd1);
    expect_("sh_adr", S_ADR, 32'd2); checkAll(); step();
    expect_("sh_lanes_lw", S_RES, 32'h00ABAB80);
    expect_("sh_lanes_pc", S_PC, 32'h38); checkAll();

    // Branches and jumps
    reset = 1'b1;
    #1;
    prog = '{encI(3, 0, 0, 1, O_IMM), encI(3, 0, 0, 2, O_IMM), encB(8, 2, 1, 0),
             encI(1, 0, 0, 5, O_IMM), encJ(8, 1), encI(1, 0, 0, 5, O_IMM), encB(8, 2, 2, 1),
             encI(32'h31, 0, 0, 6, O_IMM), encI(0, 6, 0, 7, O_JALR), NOP, NOP, NOP,
             encI(-1, 0, 0, 8, O_IMM), encB(8, 1, 8, 4), NOP, encB(8, 1, 8, 6),
             encB(8, 8, 1, 5), NOP};
    loadProg();
    reset = 1'b0;
    #1;
    step();
    step();
    expect_("beq_taken_pc", S_PC, 32'h10); step(); checkAll();
    expect_("jal_result", S_RES, 32'h14); checkAll();
    expect_("jal_pc", S_PC, 32'h18); step(); checkAll();
    expect_("bne_equal_pc", S_PC, 32'h1C); step(); checkAll();
    step();
    expect_("jalr_result", S_RES, 32'h24); checkAll();
    expect_("jalr_odd_pc", S_PC, 32'h30); step(); checkAll();
    step();
    expect_("blt_taken_pc", S_PC, 32'h3C); step(); checkAll();
    expect_("bltu_not_taken_pc", S_PC, 32'h40); step(); checkAll();
    expect_("bge_taken_pc", S_PC, 32'h48); step(); checkAll();

    // Arithmetic, shifts, upper immediates and an unknown opcode
    reset = 1'b1;
    #1;
    prog = '{encI(-1, 0, 0, 1, O_IMM), encI(1, 0, 0, 2, O_IMM), encR(0, 2, 1, 2, 3),
             encR(0, 2, 1, 3, 3), encI(4, 0, 0, 4, O_IMM), encR(32, 4, 1, 5, 5),
             encR(0, 4, 1, 5, 5), encU(32'hABCDE, 6, O_LUI), encR(32, 1, 2, 0, 7),
             encU(1, 8, O_AUIPC), encI(32'h408, 6, 5, 9, O_IMM), encI(-1, 6, 4, 9, O_IMM),
             encI(7, 0, 0, 31, O_IMM), 32'hFFFF_FFFF, encR(0, 0, 31, 0, 11),
             encI(31, 2, 1, 12, O_IMM), encI(-1, 2, 3, 13, O_IMM)};
    loadProg();
    reset = 1'b0;
    #1;
    step();
    step();
    expect_("slt_signed", S_RES, 32'd1); checkAll(); step();
    expect_("sltu_unsigned", S_RES, 32'd0); checkAll(); step();
    step();
    expect_("sra_neg", S_RES, 32'hFFFFFFFF); checkAll(); step();
    expect_("srl_neg", S_RES, 32'h0FFFFFFF); checkAll(); step();
    expect_("lui_abcde", S_RES, 32'hABCDE000); checkAll(); step();
    expect_("sub_wrap", S_RES, 32'd2); checkAll(); step();
    expect_("auipc_result", S_RES, 32'h00001024); checkAll(); step();
    expect_("srai_result", S_RES, 32'hFFABCDE0); checkAll(); step();
    expect_("xori_result", S_RES, 32'h54321FFF); checkAll(); step();
    step();
    expect_("unknown_op_memwrite", S_MW, 32'd0); checkAll();
    expect_("unknown_op_pc", S_PC, 32'h38); step(); checkAll();
    expect_("unknown_op_no_regwrite", S_RES, 32'd7); checkAll(); step();
    expect_("slli_31", S_RES, 32'h80000000); checkAll(); step();
    expect_("sltiu_neg1", S_RES, 32'd1); checkAll();

    // Asynchronous reset mid-cycle while PC=0x20, memory left untouched
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    repeat (8) step();
    expect_("pre_async_pc", S_PC, 32'h20); checkAll();
    #2;
    Ext_MemWrite = 1'b0;
    Ext_DataAdr = 32'd0;
    Ext_WriteData = 32'h5555_5555;
    reset = 1'b1;
    #1;
    expect_("async_reset_pc", S_PC, 32'd0);
    expect_("async_reset_memwrite", S_MW, 32'd0);
    expect_("async_reset_adr", S_ADR, 32'd0);
    checkAll();
    expect_("reset_no_write_mem", S_RD, 32'h00ABAB80);
    expect_("reset_hold_pc", S_PC, 32'd0);
    step();
    checkAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
